// File: rtl/pe_traffic_node.sv
// Per-PE traffic generator and checker for one leaf port of the BTree NoC.
// TX injects PktLimit packets to a fixed spatial pattern; RX checks destination and per-source order.
module pe_traffic_node #(
  parameter int Address      = 0,
  parameter int NumPE        = 16,
  parameter int AddressWidth = 4,
  parameter int DataWidth    = 32,
  parameter int TotalWidth   = 36,
  parameter int PktLimit     = 100,
  parameter int Pattern      = 0,
  parameter int Gap          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic [TotalWidth-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  input  logic [TotalWidth-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_tx_done,
  output logic [31:0]           o_tx_count,
  output logic [31:0]           o_rx_count,
  output logic                  o_err_dest,
  output logic                  o_err_seq
);

  localparam int SeqWidth = DataWidth - AddressWidth;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [AddressWidth-1:0] MyAddr   = AddressWidth'(Address);
  localparam logic [15:0]             LfsrTaps = 16'hB400;
  localparam logic [15:0]             LfsrSeed = 16'(Address + 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

  // Destinations wrap mod NumPE by truncation to AddressWidth bits.
  function automatic logic [TotalWidth-1:0] make_pkt(input logic [SeqWidth-1:0] seq,
                                                     input logic [15:0]         lfsr);
    logic [AddressWidth-1:0] dest;
    case (Pattern)
      0:       dest = AddressWidth'(Address + NumPE / 2 - 1);
      1:       dest = ~MyAddr;
      2:       dest = MyAddr + 1'b1;
      default: dest = lfsr[AddressWidth-1:0];
    endcase
    if (dest == MyAddr) dest = dest + 1'b1;
    return {dest, MyAddr, seq};
  endfunction

  logic [2:0]            state_q, state_d;
  logic [TotalWidth-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [31:0]           tx_count_q, tx_count_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  transfer;

  assign transfer = valid_q && i_data_ready;

  // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    done_d     = done_q;
    tx_count_d = tx_count_q;
    lfsr_d     = lfsr_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_LOAD;
      S_LOAD: begin
        data_d  = make_pkt(SeqWidth'(tx_count_q), lfsr_q);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (transfer) begin
          tx_count_d = tx_count_q + 32'd1;
          lfsr_d     = lfsr_step(lfsr_q);
          if (tx_count_d == 32'(PktLimit)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (!i_start) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else if (Gap == 0) begin
            // Back-to-back: next packet is built from the post-transfer count and LFSR.
            data_d = make_pkt(SeqWidth'(tx_count_d), lfsr_d);
          end else begin
            valid_d   = 1'b0;
            gap_cnt_d = 8'd0;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The reload happens on the last idle cycle, so valid stays low for exactly Gap cycles.
        if (gap_cnt_q == 8'(Gap - 1)) begin
          if (i_start) begin
            data_d  = make_pkt(SeqWidth'(tx_count_q), lfsr_q);
            valid_d = 1'b1;
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      tx_count_q <= '0;
      lfsr_q     <= LfsrSeed;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      tx_count_q <= tx_count_d;
      lfsr_q     <= lfsr_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  logic [AddressWidth-1:0] rx_dest, rx_src;
  logic [SeqWidth-1:0]     rx_seq;
  logic [SeqWidth-1:0]     exp_q [NumPE];
  logic                    ready_q, err_dest_q, err_seq_q;
  logic [31:0]             rx_count_q;
  logic                    rx_fire;

  assign rx_dest = i_data[TotalWidth-1:DataWidth];
  assign rx_src  = i_data[DataWidth-1:SeqWidth];
  assign rx_seq  = i_data[SeqWidth-1:0];
  assign rx_fire = i_data_valid && ready_q;

  // NOTE: the expected-sequence table is reset because a restart must begin every source at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      rx_count_q <= '0;
      err_dest_q <= 1'b0;
      err_seq_q  <= 1'b0;
      for (int i = 0; i < NumPE; i++) exp_q[i] <= '0;
    end else begin
      ready_q <= 1'b1;
      if (rx_fire) begin
        rx_count_q <= rx_count_q + 32'd1;
        if (rx_dest != MyAddr) err_dest_q <= 1'b1;
        if (rx_seq != exp_q[rx_src]) err_seq_q <= 1'b1;
        exp_q[rx_src] <= rx_seq + 1'b1;
      end
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_tx_done    = done_q;
  assign o_tx_count   = tx_count_q;
  assign o_data_ready = ready_q;
  assign o_rx_count   = rx_count_q;
  assign o_err_dest   = err_dest_q;
  assign o_err_seq    = err_seq_q;

endmodule

// File: doc/pe_traffic_node.md
Name: pe_traffic_node

Overview:
- Synthesizable traffic generator plus checker that attaches to one leaf port of the BTree NoC, one instance per PE.
- TX side injects PktLimit packets addressed by a fixed spatial pattern.
- RX side consumes packets delivered by the tree, checks each one's destination and per-source sequence order, and counts them.
- Statistics (counts, done, error flags) feed the system-level throughput/latency harness.

Parameters:
- Address, 0: this node's PE index, 0..NumPE-1.
- NumPE, 16: number of leaf PEs; power of 2, at least 2.
- AddressWidth, 4: equals $clog2(NumPE).
- DataWidth, 32: payload width; must be at least AddressWidth+8.
- TotalWidth, 36: equals DataWidth+AddressWidth.
- PktLimit, 100: packets to inject; 1..2^(DataWidth-AddressWidth)-1.
- Pattern, 0: 0=Tornado, 1=Complement, 2=Neighbour, 3=Uniform (LFSR).
- Gap, 0: idle cycles inserted between consecutive injections, 0..255.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low (0 = in reset).
- i_start, in, 1: level enable; TX only leaves IDLE while this is 1.
- o_data, out, TotalWidth: packet to tree.
- o_data_valid, out, 1: packet valid.
- i_data_ready, in, 1: tree can accept o_data.
- i_data, in, TotalWidth: packet from tree.
- i_data_valid, in, 1: i_data valid.
- o_data_ready, out, 1: node can accept i_data.
- o_tx_done, out, 1: all PktLimit packets accepted by tree.
- o_tx_count, out, 32: packets accepted by tree.
- o_rx_count, out, 32: packets received.
- o_err_dest, out, 1: sticky; a packet arrived with destination field not equal to Address.
- o_err_seq, out, 1: sticky; a per-source sequence gap or reorder was detected.

Behaviour:
- Packet format:
  - bits [TotalWidth-1:DataWidth] = destination.
  - bits [DataWidth-1:DataWidth-AddressWidth] = source (Address).
  - bits [DataWidth-AddressWidth-1:0] = sequence number, 0-based, incremented per accepted packet.
- Reset (rst=0, async): all outputs 0, including o_data_ready; FSM to IDLE; LFSR seeded with Address+1 (nonzero); all counters and the expected-sequence table cleared. Asserting reset mid-packet drops that packet; after release, sequence restarts at 0.
- Destination rules:
  - Tornado: (Address + NumPE/2 - 1) mod NumPE.
  - Complement: ~Address.
  - Neighbour: (Address+1) mod NumPE.
  - Uniform: low AddressWidth bits of a 16-bit Galois LFSR (taps 16,14,13,11), advanced once per accepted packet.
  - Any pattern producing dest==Address uses (dest+1) mod NumPE instead.
- TX FSM:
  - IDLE: go to LOAD when i_start=1.
  - LOAD: register o_data; set o_data_valid=1 next cycle; go to SEND.
  - SEND: hold o_data/o_data_valid stable until a cycle with o_data_valid&&i_data_ready (transfer at that posedge). On transfer, o_tx_count++ and seq++. If o_tx_count reaches PktLimit go to DONE; else if Gap=0 go straight to LOAD-equivalent so the next packet is valid the following cycle (1 packet/cycle sustainable); else go to WAIT.
  - WAIT: o_data_valid=0 for exactly Gap cycles, then LOAD.
  - DONE: o_tx_done=1 and o_data_valid=0 until reset.
  - i_start falling mid-SEND does not withdraw valid; the FSM returns to IDLE only after the current transfer.
- RX:
  - o_data_ready=1 from the first clk edge after reset release; always accepts, no backpressure.
  - On i_data_valid&&o_data_ready: o_rx_count++.
  - If dest!=Address, set o_err_dest.
  - Look up exp[src] (NumPE entries, DataWidth-AddressWidth bits each). If seq!=exp[src], set o_err_seq. In both cases exp[src] <= seq+1.
  - Statistics update 1 cycle after acceptance. Sticky flags clear only on reset.
- Counters are 32-bit and wrap modulo 2^32 without flagging. The sequence field never wraps within PktLimit.

Test Plan:
- Tornado, Address=3, NumPE=16, PktLimit=4, Gap=0, i_data_ready=1: four consecutive cycles of valid; o_data = {4'd10, 4'd3, 28'd0..3}; o_tx_done=1 one cycle after the 4th transfer; o_tx_count=4.
- Backpressure: i_data_ready held 0 for 5 cycles during SEND -> o_data stable and valid all 5 cycles; the packet transfers once ready rises; no duplicate and no skipped sequence number.
- Gap=3, PktLimit=3: valid-high cycles are separated by exactly 3 valid-low cycles; total tx_count=3.
- RX: inject src=5 seq 0,1,2 and then seq 4 to Address=7 -> rx_count=4, o_err_seq=1 only after the 4th packet, o_err_dest=0. Then a packet with dest=6 -> o_err_dest=1.
- Complement, Address=0 -> dest=15. Uniform with NumPE=2 -> destination is never equal to Address.
- Reset asserted mid-SEND after 2 transfers -> all outputs 0 immediately. After release with i_start=1, the first packet carries seq 0 and tx_count restarts from 0.
